alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised ALU for the BPF datapath: executes one arithmetic/logic operation per transaction on W-bit operands under a valid/ready handshake. It keeps the existing 7-opcode encoding, adds shifts, XOR, modulo and negate, and reports errors. Multiply, divide and modulo run iteratively instead of as combinational arrays. It sits between the instruction decoder (operand/opcode source) and the register-file writeback stage (result sink).

## Interface
- `W`, 32: operand and result width; any value ≥ 4.
- `SW`, $clog2(W): shift-amount width, derived; not to be overridden.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: operands and opcode presented.
- `in_ready` out 1: block accepts a transaction this cycle.
- `op` in 4: opcode, see Operation.
- `a` in W: first operand (dst).
- `b` in W: second operand (src).
- `out_valid` out 1: result held and valid.
- `out_ready` in 1: sink accepts the result.
- `result` out W: operation result.
- `err` out 1: qualified by `out_valid`; set on divide/modulo by zero or on an undefined opcode.

## Operation
- Opcodes: 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 AND, 6 OR, 7 NOT (~a), 8 LSH (a << b[SW-1:0]), 9 RSH (logical, a >> b[SW-1:0]), 10 MOD, 11 XOR, 12 NEG (0 - a).
- Opcodes 0 and 13–15 are undefined: result 0, err 1.
- All arithmetic is unsigned modulo 2^W.
  - MUL returns the low W bits of the product.
  - DIV returns the floor quotient; MOD returns the remainder.
- Shift amount is masked to SW bits; the upper bits of `b` are ignored.
- DIV with b = 0: result 0, err 1.
- MOD with b = 0: result = a, err 1.
- No other operation sets err.
- State machine, one of three states:
  - IDLE: `in_ready` = 1.
    - On `in_valid` high, latch `op`, `a` and `b`.
    - Single-cycle ops (ADD, SUB, AND, OR, NOT, LSH, RSH, XOR, NEG, undefined): compute, register the result, go to DONE.
    - MUL/DIV/MOD: load the iteration counter with W, go to BUSY.
    - DIV/MOD with b = 0: go straight to DONE, with no iterations.
  - BUSY: one iteration per cycle.
    - MUL: shift-add, consuming one multiplier bit (LSB first) per cycle.
    - DIV/MOD: restoring division, producing one quotient bit (MSB first) per cycle.
    - Counter decrements each cycle; when it reaches 0, register the result and go to DONE.
  - DONE: `out_valid` = 1; `result` and `err` are held stable.
    - On `out_ready` high, go to IDLE.
- `in_ready` is low in BUSY and DONE, so no new transaction is accepted in the cycle of the output handshake.
- Operand inputs are ignored whenever `in_ready` is low.

## Timing
- Reset (`rst_n` low at a clock edge), including mid-operation:
  - state goes to IDLE and any in-flight transaction is discarded with no output;
  - `out_valid` = 0, `result` = 0, `err` = 0, iteration counter = 0;
  - `in_ready` reads 0 while `rst_n` is low and 1 in the first cycle after release.
- Latency, from the accept edge to the first cycle with `out_valid` high:
  - single-cycle ops: 1 cycle;
  - MUL, DIV, MOD: W + 1 cycles;
  - DIV/MOD by zero: 1 cycle.
- Throughput: one transaction per 2 cycles for single-cycle ops when `out_ready` is tied high.
- Backpressure: DONE holds indefinitely while `out_ready` is low, with `result` and `err` constant.
- `out_ready` high outside DONE has no effect.
- `in_valid` and `out_ready` arriving in the same cycle: only the state's own handshake is honoured.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_ADD` … `OP_NEG` as a 4-bit enum typedef `alu_op_t`;
  - state typedef `alu_state_t` {IDLE, BUSY, DONE};
  - helper function `is_multicycle(alu_op_t)`.
- One sub-module, `alu_mc_iter`, holds the shared shift-add/restoring-divide datapath.
  - Registers: accumulator/remainder (W+1 bits), quotient/multiplier shift register (W bits), counter.
  - Controls: `start`, `mode` (mul/div), `done`; outputs `prod_lo`, `quot`, `rem`.
- The top level contains the FSM, the single-cycle datapath, result muxing and error logic.

## Test plan
- W=8. Reset mid-MUL: accept MUL a=3 b=5, assert `rst_n` low at cycle 3 → no `out_valid` appears; after release `in_ready` = 1 and `result` = 0.
- W=8. ADD 0xF0+0x20, NEG a=1, LSH a=0x81 b=0x09 (masked to 1) → 0x10, 0xFF, 0x02 respectively, each with `out_valid` exactly 1 cycle after accept and err = 0.
- W=8. MUL 0x13×0x11 → 0x43 (low byte of 0x143); DIV 200/7 → 28; MOD 200/7 → 4. Each shows `out_valid` at cycle 9 after accept.
- W=8. DIV 55/0 → result 0, err 1, latency 1. MOD 55/0 → result 55, err 1. Opcode 14 → result 0, err 1.
- W=8. Backpressure: hold `out_ready` low for 5 cycles after XOR 0xAA^0x0F → `result` stays 0xA5 and `in_ready` stays 0 for those cycles; raise `out_ready` → IDLE on the next cycle.
- W=32. Random regression of 10,000 transactions with random `out_ready` stalls: compare against a reference model and check latency per opcode class.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state definitions for the multi-cycle BPF ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_NOT = 4'd7,
        OP_LSH = 4'd8,
        OP_RSH = 4'd9,
        OP_MOD = 4'd10,
        OP_XOR = 4'd11,
        OP_NEG = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    function automatic logic is_multicycle(alu_op_t op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_divide(alu_op_t op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative datapath: shift-add multiply (multiplier LSB first) and
// restoring divide (quotient MSB first), one bit per cycle.
module alu_mc_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] prod_lo,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);
    localparam int CW = $clog2(W) + 1;

    logic [W:0]    r_acc;
    logic [W-1:0]  r_sr;
    logic [W-1:0]  r_opnd;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_mode;

    logic [W:0]    w_sum;
    logic [W:0]    w_shift;
    logic [W:0]    w_acc_nxt;
    logic [W-1:0]  w_sr_nxt;

    // Next-step values; the top samples them on the final iteration so the result lands with the last bit.
    always_comb begin
        w_acc_nxt = r_acc;
        w_sr_nxt  = r_sr;
        w_sum     = r_acc + {1'b0, (r_sr[0] ? r_opnd : {W{1'b0}})};
        w_shift   = {r_acc[W-1:0], r_sr[W-1]};
        if (r_mode) begin
            if (w_shift >= {1'b0, r_opnd}) begin
                w_acc_nxt = w_shift - {1'b0, r_opnd};
                w_sr_nxt  = {r_sr[W-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_shift;
                w_sr_nxt  = {r_sr[W-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = {1'b0, w_sum[W:1]};
            w_sr_nxt  = {w_sum[0], r_sr[W-1:1]};
        end
    end

    // Operand load on start, then one iteration per cycle until the counter empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= {(W+1){1'b0}};
            r_sr   <= {W{1'b0}};
            r_opnd <= {W{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_busy <= 1'b0;
            r_mode <= 1'b0;
        end else if (start) begin
            r_acc  <= {(W+1){1'b0}};
            r_sr   <= mode ? a : b;
            r_opnd <= mode ? b : a;
            r_cnt  <= CW'(W);
            r_busy <= 1'b1;
            r_mode <= mode;
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_sr  <= w_sr_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign done    = r_busy && (r_cnt == CW'(1));
    assign prod_lo = w_sr_nxt;
    assign quot    = w_sr_nxt;
    assign rem     = w_acc_nxt[W-1:0];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle datapath, result and error muxing.
module alu_mc
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         err
);
    localparam int SW = $clog2(W);

    alu_state_t   r_state;
    alu_op_t      r_op;
    logic [W-1:0] r_result;
    logic         r_err;
    logic         r_out_valid;

    alu_op_t      w_op;
    logic         w_div_zero;
    logic         w_start;
    logic [W-1:0] w_single_res;
    logic         w_single_err;
    logic [W-1:0] w_iter_res;
    logic         w_iter_done;
    logic [W-1:0] w_prod_lo;
    logic [W-1:0] w_quot;
    logic [W-1:0] w_rem;

    assign w_op       = alu_op_t'(op);
    assign w_div_zero = is_divide(w_op) && (b == {W{1'b0}});
    assign w_start    = (r_state == IDLE) && in_valid && is_multicycle(w_op) && !w_div_zero;

    alu_mc_iter #(.W(W)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .mode    (w_op != OP_MUL),
        .a       (a),
        .b       (b),
        .done    (w_iter_done),
        .prod_lo (w_prod_lo),
        .quot    (w_quot),
        .rem     (w_rem)
    );

    // Single-cycle results; DIV/MOD only reach this path with a zero divisor.
    always_comb begin
        w_single_res = {W{1'b0}};
        w_single_err = 1'b0;
        case (w_op)
            OP_ADD: w_single_res = a + b;
            OP_SUB: w_single_res = a - b;
            OP_AND: w_single_res = a & b;
            OP_OR:  w_single_res = a | b;
            OP_NOT: w_single_res = ~a;
            OP_LSH: w_single_res = a << b[SW-1:0];
            OP_RSH: w_single_res = a >> b[SW-1:0];
            OP_XOR: w_single_res = a ^ b;
            OP_NEG: w_single_res = {W{1'b0}} - a;
            OP_MUL: w_single_res = {W{1'b0}};
            OP_DIV: w_single_err = 1'b1;
            OP_MOD: begin
                w_single_res = a;
                w_single_err = 1'b1;
            end
            default: w_single_err = 1'b1;
        endcase
    end

    // Select the iterative result that matches the latched opcode.
    always_comb begin
        w_iter_res = {W{1'b0}};
        case (r_op)
            OP_MUL:  w_iter_res = w_prod_lo;
            OP_DIV:  w_iter_res = w_quot;
            OP_MOD:  w_iter_res = w_rem;
            default: w_iter_res = {W{1'b0}};
        endcase
    end

    // Control FSM with registered result, error and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_ADD;
            r_result    <= {W{1'b0}};
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op <= w_op;
                        if (w_start) begin
                            r_state <= BUSY;
                        end else begin
                            r_result    <= w_single_res;
                            r_err       <= w_single_err;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (w_iter_done) begin
                        r_result    <= w_iter_res;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // in_ready is forced low while reset is held so nothing is offered mid-reset.
    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at W=8: directed cases plus randomized traffic
// against a plain-arithmetic reference model, with random output stalls.
module tb_alu_mc;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         lat;
        int         acc_cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       err;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    logic rdy_rand = 1'b0;
    logic rdy_val = 1'b1;
    exp_t exp_q[$];

    logic       pending = 1'b0;
    logic [7:0] held_res;
    logic       held_err;
    exp_t       mon_e;

    alu_mc #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Sink readiness: random stalls or a fixed level, changed away from the clock edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: unsigned W=8 arithmetic straight from the operation table.
    function automatic logic [8:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        logic       e;
        r = 8'h00;
        e = 1'b0;
        case (o)
            4'd1:  r = x + y;
            4'd2:  r = x - y;
            4'd3:  r = x * y;
            4'd4:  if (y == 8'd0) e = 1'b1; else r = x / y;
            4'd5:  r = x & y;
            4'd6:  r = x | y;
            4'd7:  r = ~x;
            4'd8:  r = x << y[2:0];
            4'd9:  r = x >> y[2:0];
            4'd10: if (y == 8'd0) begin r = x; e = 1'b1; end else r = x % y;
            4'd11: r = x ^ y;
            4'd12: r = 8'd0 - x;
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    function automatic int model_lat(input logic [3:0] o, input logic [7:0] y);
        if (o == 4'd3 || ((o == 4'd4 || o == 4'd10) && y != 8'd0)) return 9;
        return 1;
    endfunction

    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] r, input logic e, input int l);
        exp_t t_e;
        int   t;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        t        = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (in_ready) begin
            t_e.res     = r;
            t_e.err     = e;
            t_e.lat     = l;
            t_e.acc_cyc = cyc + 1;
            exp_q.push_back(t_e);
        end else begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    // Monitor: pops one expectation per new output, then checks it holds until taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
        end else if (out_valid) begin
            if (!pending) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_output: result=0x%0h err=%0b, required no output", result, err);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", 32'(result), 32'(mon_e.res));
                    chk("err", 32'(err), 32'(mon_e.err));
                    chk("latency", 32'(cyc - mon_e.acc_cyc + 1), 32'(mon_e.lat));
                end
                held_res = result;
                held_err = err;
                pending  = 1'b1;
            end else begin
                chk("hold_result", 32'(result), 32'(held_res));
                chk("hold_err", 32'(err), 32'(held_err));
            end
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            if (out_ready) pending = 1'b0;
        end else begin
            pending = 1'b0;
        end
    end

    initial begin
        logic [8:0] m;
        int         t;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 4'd0;
        a        = 8'd0;
        b        = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(4'd1, 8'hF0, 8'h20, 8'h10, 1'b0, 1);
        send(4'd12, 8'h01, 8'h00, 8'hFF, 1'b0, 1);
        send(4'd8, 8'h81, 8'h09, 8'h02, 1'b0, 1);
        send(4'd3, 8'h13, 8'h11, 8'h43, 1'b0, 9);
        send(4'd4, 8'd200, 8'd7, 8'd28, 1'b0, 9);
        send(4'd10, 8'd200, 8'd7, 8'd4, 1'b0, 9);
        send(4'd4, 8'd55, 8'd0, 8'd0, 1'b1, 1);
        send(4'd10, 8'd55, 8'd0, 8'd55, 1'b1, 1);
        send(4'd14, 8'h12, 8'h34, 8'h00, 1'b1, 1);
        send(4'd0, 8'h12, 8'h34, 8'h00, 1'b1, 1);

        // Reset in the middle of a MUL: the transaction must vanish.
        send(4'd3, 8'd3, 8'd5, 8'd15, 1'b0, 9);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rel_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (12) @(posedge clk);
        #1;

        // Backpressure on an XOR result.
        rdy_val = 1'b0;
        @(posedge clk);
        #1;
        send(4'd11, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_result", 32'(result), 32'hA5);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        rdy_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        rdy_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ro;
            logic [7:0] ra;
            logic [7:0] rb;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            ro = 4'($urandom);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            m  = model(ro, ra, rb);
            send(ro, ra, rb, m[7:0], m[8], model_lat(ro, rb));
        end

        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
